// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package mem_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-requester arbiter producing a one-hot grant.
// With MEM_ARB_FIXED_PRIO_EN defined the tie-break is fixed to port 0.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  port_id_t   last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign grant[0] = enable & valid0;
    assign grant[1] = enable & valid1 & ~valid0;
`else
    // On a tie the port that did not win last time is served.
    assign grant[0] = enable & valid0 & (~valid1 | last_grant);
    assign grant[1] = enable & valid1 & (~valid0 | ~last_grant);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between two masters, one access in flight.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state;
    state_t        state_next;
    logic [1:0]    grant;
    port_id_t      last_grant;
    port_id_t      win_id;
    port_id_t      op_id;
    logic          op_we;
    logic          accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant)
    );

    assign sel_we    = win_id ? req1_we    : req0_we;
    assign sel_addr  = win_id ? req1_addr  : req0_addr;
    assign sel_wdata = win_id ? req1_wdata : req0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational accept handshake
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        win_id     = 1'b0;
        req0_ready = grant[0];
        req1_ready = grant[1];
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    win_id     = port_id_t'(grant[1]);
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= win_id;
        end
    end
`endif

    // Memory command, read return and busy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_id       <= 1'b0;
            op_we       <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
            busy        <= 1'b0;
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            busy        <= (state_next != IDLE);
            if (accept) begin
                op_id     <= win_id;
                op_we     <= sel_we;
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == WAIT && !op_we) begin
                if (op_id) begin
                    req1_rdata  <= mem_rdata;
                    req1_rvalid <= 1'b1;
                end else begin
                    req0_rdata  <= mem_rdata;
                    req0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported 256×16 synchronous program/data memory between the CPU core (port 0: fetch, LDI operand and immediate reads) and a loader/IO master (port 1: memory initialisation, register-file dumps). It sits between both masters and the RAM array and sequences every access through a three-state FSM. It enforces one memory operation in flight, with fair (round-robin) or fixed-priority grant.

## Interface
- AW, 8, memory address width (256 words)
- DW, 16, data word width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present; payload held stable until accepted
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  word address
- req0_wdata / req1_wdata  in  DW  write data
- req0_ready / req1_ready  out  1  accept strobe; transfer when valid & ready
- req0_rvalid / req1_rvalid  out  1  one-cycle read-data strobe
- req0_rdata / req1_rdata  out  DW  read data, valid while rvalid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - IDLE: arbitrate; on accept, latch winner id, we, addr and wdata → ISSUE.
  - ISSUE: drive mem_en = 1, mem_we/addr/wdata from latches → WAIT.
  - WAIT: for reads, capture mem_rdata into the winner's rdata register and set its rvalid for the next cycle → IDLE unconditionally.
- Ready is combinational, asserted only in IDLE, to exactly one requester, and only if that requester's valid is high.
- Arbitration, round-robin:
  - Single valid requester wins.
  - Both valid: the requester not in last_grant wins.
  - last_grant updates on each accept.
- Writes complete in ISSUE. Writes produce no rvalid.
- rdata of the non-winning port holds its previous value. rvalid is never high on both ports at once.
- A requester dropping valid without ready is a protocol violation; behaviour is unspecified.
- Reset values:
  - state = IDLE
  - last_grant = 1 (port 0 wins first tie)
  - all ready, rvalid, mem_en and mem_we = 0
  - mem_addr, mem_wdata, rdata = 0
  - busy = 0
- Reset mid-operation: the in-flight access is abandoned. A write already issued in ISSUE stands. A pending read never produces rvalid.

## Timing
- Accept in cycle T.
- mem_en high in T+1 only.
- mem_rdata sampled at the end of T+2.
- rvalid/rdata high in T+3, coinciding with the next IDLE, where a new accept may occur.
- Sustained throughput: one access per 3 cycles. Read latency from accept: 3 cycles.
- Simultaneous requests are served alternately, so each port's worst-case wait is 3 cycles.
- Addresses use the full 8 bits with no wrap logic; 8'hFF is a legal address.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie, and last_grant is not implemented. Port 1 can starve while port 0 requests continuously.
- Undefined (default): round-robin as described above.

## Structure
- Package mem_arb_pkg holds:
  - AW_DEF/DW_DEF constants
  - state enum {IDLE, ISSUE, WAIT}
  - port-id type (1 bit)
- One sub-module, rr_arbiter2:
  - Inputs: two valids, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational.
  - Its tie-break reduces to fixed priority under MEM_ARB_FIXED_PRIO_EN.

## Test plan
- Reset released, no requests → busy = 0; ready, rvalid and mem_en all 0 for 10 cycles.
- Port 0 write addr 8'h10 data 16'hBEEF, then read 8'h10 → mem_en pulses at T+1, and req0_rvalid with rdata = 16'hBEEF 3 cycles after the read accept.
- Both ports valid continuously with reads from 8'h01 (p0) and 8'h02 (p1):
  - Round-robin: grants alternate p0, p1, p0, … every 3 cycles.
  - Fixed-priority build: only p0 is granted.
- Port 1 writes 16'h1234 to 8'hFF, port 0 reads 8'hFF afterwards → 16'h1234, confirming the top address works.
- rst asserted in WAIT of a p1 read → no req1_rvalid; state IDLE next cycle; first tie after reset granted to p0.
- Read accepted while the previous read's rvalid is high in the same IDLE cycle → both handshakes complete, with rdata unchanged on the idle port.
